// File: rtl/branch_resolve_unit.sv
// Branch resolution and direct-mapped branch history/target prediction for the RV32I pipeline.
// Define BRANCH_PRED_EN to build the prediction table; left undefined, predictions are tied to 0.
module branch_resolve_unit #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned IDX_BITS = 6,
   parameter int unsigned CNT_BITS = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] f_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_br_target,
   input  logic [XLEN-1:0] ex_jalr_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   input  logic            Z,
   input  logic            N,
   input  logic            C,
   input  logic [2:0]      RF_sel_in,
   output logic [2:0]      RF_sel_out,
   output logic [1:0]      PC_sel,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     br_cnt,
   output logic [31:0]     mis_cnt
);

   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   logic            is_b;
   logic            is_jal;
   logic            is_jalr;
   logic            is_xfer;
   logic            actual;
   logic            mispred;
   logic            flush_int;
   logic [XLEN-1:0] correct_pc;
   logic [1:0]      pc_src;
   logic [31:0]     br_cnt_q, br_cnt_d;
   logic [31:0]     mis_cnt_q, mis_cnt_d;

   always_comb begin
      is_b    = (ex_opcode == OpBranch) && (ex_funct3 != 3'b010) && (ex_funct3 != 3'b011);
      is_jal  = (ex_opcode == OpJal);
      is_jalr = (ex_opcode == OpJalr) && (ex_funct3 == 3'b000);
      is_xfer = ex_valid && (is_b || is_jal || is_jalr);
      actual  = is_jal || is_jalr;
      if (is_b) begin
         case (ex_funct3)
            3'b000:  actual = Z;
            3'b001:  actual = !Z;
            3'b100:  actual = N;
            3'b101:  actual = !N;
            3'b110:  actual = C;
            3'b111:  actual = !C;
            default: actual = 1'b0;
         endcase
      end
      correct_pc = ex_pc + XLEN'(4);
      pc_src     = 2'b00;
      if (actual) begin
         if (is_jalr) begin
            correct_pc = ex_jalr_target;
            pc_src     = 2'b11;
         end else begin
            correct_pc = ex_br_target;
            pc_src     = is_jal ? 2'b10 : 2'b01;
         end
      end
   end

   assign flush_int   = !rst && is_xfer && mispred;
   assign flush       = flush_int;
   assign redirect_pc = flush_int ? correct_pc : '0;
   assign PC_sel      = (!rst && is_xfer) ? pc_src : 2'b00;
   assign RF_sel_out  = rst ? 3'b000 : RF_sel_in;

   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (is_xfer) br_cnt_d = br_cnt_q + 32'd1;
      if (flush_int) mis_cnt_d = mis_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign br_cnt  = br_cnt_q;
   assign mis_cnt = mis_cnt_q;

`ifdef BRANCH_PRED_EN
   localparam int unsigned Entries  = 2 ** IDX_BITS;
   localparam int unsigned TagBits  = XLEN - IDX_BITS - 2;
   localparam logic [CNT_BITS-1:0] CntMax   = '1;
   localparam logic [CNT_BITS-1:0] CntOne   = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CntWeakT = {1'b1, {(CNT_BITS-1){1'b0}}};
   localparam logic [CNT_BITS-1:0] CntWeakN = {1'b0, {(CNT_BITS-1){1'b1}}};

   logic [Entries-1:0]  valid_q;
   logic [TagBits-1:0]  tag_q [Entries];
   logic [XLEN-1:0]     tgt_q [Entries];
   logic [CNT_BITS-1:0] cnt_q [Entries];

   logic [IDX_BITS-1:0] f_idx, e_idx;
   logic [TagBits-1:0]  f_tag, e_tag;
   logic                e_hit;
   logic                upd;
   logic                unused_pc_lsb;

   assign f_idx = f_pc[IDX_BITS+1:2];
   assign f_tag = f_pc[XLEN-1:IDX_BITS+2];
   assign e_idx = ex_pc[IDX_BITS+1:2];
   assign e_tag = ex_pc[XLEN-1:IDX_BITS+2];
   assign unused_pc_lsb = ^f_pc[1:0];

   // Lookup reads the registered table, so a same-cycle update to the same entry is not visible.
   assign pred_taken  = !rst && valid_q[f_idx] && (tag_q[f_idx] == f_tag)
                        && cnt_q[f_idx][CNT_BITS-1];
   assign pred_target = pred_taken ? tgt_q[f_idx] : '0;

   assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
   assign upd     = is_xfer && (is_b || is_jal);
   assign mispred = (actual != ex_pred_taken) || (actual && (ex_pred_target != correct_pc));

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < Entries; i++) cnt_q[i] <= CntWeakN;
      end else if (upd) begin
         if (e_hit) begin
            if (actual) begin
               if (cnt_q[e_idx] != CntMax) cnt_q[e_idx] <= cnt_q[e_idx] + CntOne;
               tgt_q[e_idx] <= correct_pc;
            end else if (cnt_q[e_idx] != '0) begin
               cnt_q[e_idx] <= cnt_q[e_idx] - CntOne;
            end
         end else if (actual) begin
            valid_q[e_idx] <= 1'b1;
            tag_q[e_idx]   <= e_tag;
            tgt_q[e_idx]   <= correct_pc;
            cnt_q[e_idx]   <= is_jal ? CntMax : CntWeakT;
         end
      end
   end
`else
   logic unused_pred;

   // Without a predictor every fetch assumes not-taken, so any taken transfer is a redirect.
   assign pred_taken  = 1'b0;
   assign pred_target = '0;
   assign mispred     = actual;
   assign unused_pred = ^{f_pc, ex_pred_taken, ex_pred_target};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed steps then randomized traffic,
// checked against a behavioural table model; honours BRANCH_PRED_EN like the design.
module tb_branch_resolve_unit;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned IDX_BITS = 6;
   localparam int unsigned CNT_BITS = 2;
   localparam int unsigned ENTRIES  = 2 ** IDX_BITS;
   localparam int          CNT_MAX  = (2 ** CNT_BITS) - 1;
   localparam int          CNT_HALF = 2 ** (CNT_BITS - 1);
   localparam logic [6:0]  OP_B     = 7'b1100011;
   localparam logic [6:0]  OP_JAL   = 7'b1101111;
   localparam logic [6:0]  OP_JALR  = 7'b1100111;
   localparam logic [6:0]  OP_ALU   = 7'b0110011;
`ifdef BRANCH_PRED_EN
   localparam bit PredEn = 1'b1;
`else
   localparam bit PredEn = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] f_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            ex_valid;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_pc, ex_br_target, ex_jalr_target, ex_pred_target;
   logic            ex_pred_taken;
   logic            Z, N, C;
   logic [2:0]      RF_sel_in, RF_sel_out;
   logic [1:0]      PC_sel;
   logic            flush;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     br_cnt, mis_cnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(
      .XLEN     (XLEN),
      .IDX_BITS (IDX_BITS),
      .CNT_BITS (CNT_BITS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .f_pc           (f_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_funct3      (ex_funct3),
      .ex_pc          (ex_pc),
      .ex_br_target   (ex_br_target),
      .ex_jalr_target (ex_jalr_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .Z              (Z),
      .N              (N),
      .C              (C),
      .RF_sel_in      (RF_sel_in),
      .RF_sel_out     (RF_sel_out),
      .PC_sel         (PC_sel),
      .flush          (flush),
      .redirect_pc    (redirect_pc),
      .br_cnt         (br_cnt),
      .mis_cnt        (mis_cnt)
   );

   // Reference model: one entry per index, counters as plain integers.
   bit          m_valid [ENTRIES];
   logic [31:0] m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_cnt   [ENTRIES];
   int unsigned m_br, m_mis;
   int unsigned checks = 0;
   int unsigned errors = 0;

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   task automatic chk(input string step, input string field, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s: observed %h expected %h", step, field, obs, exp);
      end
   endtask

   task automatic m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
      int unsigned i;
      i  = idx_of(pc);
      tk = PredEn && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= CNT_HALF);
      tg = tk ? m_tgt[i] : 32'h0;
   endtask

   // kind: 0 not a valid transfer, 1 branch, 2 JAL, 3 JALR
   task automatic m_resolve(output int kind, output bit act, output logic [31:0] cpc,
                            output logic [1:0] sel, output bit fl);
      kind = 0;
      act  = 1'b0;
      if (ex_opcode == OP_B && ex_funct3 != 3'b010 && ex_funct3 != 3'b011) begin
         kind = 1;
         case (ex_funct3)
            3'b000:  act = Z;
            3'b001:  act = !Z;
            3'b100:  act = N;
            3'b101:  act = !N;
            3'b110:  act = C;
            default: act = !C;
         endcase
      end else if (ex_opcode == OP_JAL) begin
         kind = 2;
         act  = 1'b1;
      end else if (ex_opcode == OP_JALR && ex_funct3 == 3'b000) begin
         kind = 3;
         act  = 1'b1;
      end
      if (!ex_valid) kind = 0;
      if (!act) cpc = ex_pc + 32'd4;
      else if (kind == 3) cpc = ex_jalr_target;
      else cpc = ex_br_target;
      sel = (kind == 0 || !act) ? 2'b00 : 2'(kind);
      if (PredEn)
         fl = (kind != 0) && ((act != ex_pred_taken) || (act && ex_pred_target != cpc));
      else
         fl = (kind != 0) && act;
   endtask

   task automatic m_clock(input int kind, input bit act, input logic [31:0] cpc, input bit fl);
      int unsigned i;
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_cnt[k]   = CNT_HALF - 1;
         end
         m_br  = 0;
         m_mis = 0;
      end else begin
         if (kind != 0) m_br++;
         if (fl) m_mis++;
         if (kind == 1 || kind == 2) begin
            i = idx_of(ex_pc);
            if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
               if (act) begin
                  if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                  m_tgt[i] = cpc;
               end else if (m_cnt[i] > 0) begin
                  m_cnt[i]--;
               end
            end else if (act) begin
               m_valid[i] = 1'b1;
               m_tag[i]   = tag_of(ex_pc);
               m_tgt[i]   = cpc;
               m_cnt[i]   = (kind == 2) ? CNT_MAX : CNT_HALF;
            end
         end
      end
   endtask

   // Check the combinational outputs, clock once, then check the counters.
   task automatic cycle(input string step);
      bit          etk, act, fl;
      logic [31:0] etg, cpc;
      logic [1:0]  sel;
      int          kind;
      #1;
      m_predict(f_pc, etk, etg);
      m_resolve(kind, act, cpc, sel, fl);
      if (rst) begin
         etk  = 1'b0;
         etg  = 32'h0;
         sel  = 2'b00;
         fl   = 1'b0;
         kind = 0;
      end
      chk(step, "pred_taken", 32'(pred_taken), 32'(etk));
      chk(step, "pred_target", pred_target, etg);
      chk(step, "flush", 32'(flush), 32'(fl));
      chk(step, "PC_sel", 32'(PC_sel), 32'(sel));
      chk(step, "redirect_pc", redirect_pc, fl ? cpc : 32'h0);
      chk(step, "RF_sel_out", 32'(RF_sel_out), rst ? 32'h0 : 32'(RF_sel_in));
      @(posedge clk);
      m_clock(kind, act, cpc, fl);
      #1;
      chk(step, "br_cnt", br_cnt, m_br);
      chk(step, "mis_cnt", mis_cnt, m_mis);
   endtask

   task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] brt, input logic [31:0] jt,
                         input logic ptk, input logic [31:0] ptg, input logic z, n, c);
      ex_valid       = v;
      ex_opcode      = op;
      ex_funct3      = f3;
      ex_pc          = pc;
      ex_br_target   = brt;
      ex_jalr_target = jt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptg;
      Z              = z;
      N              = n;
      C              = c;
   endtask

   logic [31:0] pc_pool [8] = '{32'h100, 32'h104, 32'h1100, 32'h200, 32'h2fc,
                                32'hfffffffc, 32'h400, 32'h3100};

   initial begin
      bit          ptk;
      logic [31:0] ptg, pc, brt;
      logic [6:0]  op;
      int          r;

      rst       = 1'b1;
      f_pc      = 32'h100;
      RF_sel_in = 3'b101;
      set_ex(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle("reset0");
      cycle("reset1");
      rst = 1'b0;
      cycle("idle");
      chk("post_reset", "pred_taken", 32'(pred_taken), 32'h0);
      chk("post_reset", "br_cnt", br_cnt, 32'h0);

      // Unpredicted taken BEQ allocates weakly taken.
      set_ex(1'b1, OP_B, 3'b000, 32'h100, 32'h140, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("beq_taken", "flush", 32'(flush), 32'h1);
      chk("beq_taken", "redirect_pc", redirect_pc, 32'h140);
      cycle("beq_taken");
      set_ex(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle("beq_lookup");

      for (int k = 0; k < 2; k++) begin
         m_predict(32'h100, ptk, ptg);
         set_ex(1'b1, OP_B, 3'b000, 32'h100, 32'h140, 32'h0, ptk, ptg, 1'b0, 1'b0, 1'b0);
         cycle("beq_not_taken");
      end
      set_ex(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle("beq_decayed");

      // Unsigned compares resolve from the borrow flag only.
      f_pc = 32'h180;
      set_ex(1'b1, OP_B, 3'b110, 32'h180, 32'h1c0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle("bltu");
      set_ex(1'b1, OP_B, 3'b111, 32'h180, 32'h1c0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle("bgeu");

      f_pc = 32'h200;
      set_ex(1'b1, OP_JALR, 3'b000, 32'h200, 32'h0, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("jalr", "PC_sel", 32'(PC_sel), 32'h3);
      cycle("jalr");
      set_ex(1'b1, OP_B, 3'b010, 32'h200, 32'h240, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      cycle("f3_010");
      set_ex(1'b1, OP_JAL, 3'b000, 32'h400, 32'h800, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle("jal");
      f_pc = 32'h400;
      set_ex(1'b0, OP_B, 3'b001, 32'h100, 32'h140, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle("bne_invalid");

      // Reset in the middle of a taken branch drops its update.
      rst = 1'b1;
      set_ex(1'b1, OP_B, 3'b000, 32'h100, 32'h140, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle("mid_reset");
      rst = 1'b0;
      set_ex(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      f_pc = 32'h100;
      cycle("after_reset_100");
      f_pc = 32'h400;
      cycle("after_reset_400");

      for (int it = 0; it < 500; it++) begin
         r  = $urandom_range(0, 9);
         op = (r < 6) ? OP_B : (r == 6) ? OP_JAL : (r < 9) ? OP_JALR : OP_ALU;
         pc  = pc_pool[$urandom_range(0, 7)];
         brt = pc_pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 1) * 16);
         if ($urandom_range(0, 3) != 0) begin
            m_predict(pc, ptk, ptg);
         end else begin
            ptk = 1'($urandom_range(0, 1));
            ptg = pc_pool[$urandom_range(0, 7)];
         end
         set_ex(1'($urandom_range(0, 9) != 0), op, 3'($urandom_range(0, 7)), pc, brt,
                brt & 32'hffff_fffe, ptk, ptg, 1'($urandom), 1'($urandom), 1'($urandom));
         f_pc      = pc_pool[$urandom_range(0, 7)];
         RF_sel_in = 3'($urandom);
         rst       = ($urandom_range(0, 59) == 0);
         cycle("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch-resolution and dynamic prediction block for the RV32I pipeline. It replaces static not-taken PC selection with a direct-mapped branch history and target table, giving a fetch-stage prediction and resolving the prediction in execute. It drives the PC-select mux, the pipeline flush and the redirect address. It also corrects unsigned-compare resolution to use the carry/borrow flag, and keeps branch and mispredict performance counters.

## Interface
- XLEN, 32: datapath/PC width.
- IDX_BITS, 6: table index width; the table holds 2^IDX_BITS entries.
- CNT_BITS, 2: saturating direction-counter width (≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- f_pc  in  XLEN  fetch-stage PC.
- pred_taken  out  1  fetch prediction, taken.
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0.
- ex_valid  in  1  execute-stage instruction is valid (not flushed).
- ex_opcode  in  7, ex_funct3  in  3  execute-stage instruction fields.
- ex_pc  in  XLEN  execute-stage instruction PC.
- ex_br_target  in  XLEN  computed B/JAL target.
- ex_jalr_target  in  XLEN  computed JALR target (LSB already cleared).
- ex_pred_taken  in  1, ex_pred_target  in  XLEN  prediction carried down the pipeline.
- Z, N, C  in  1 each  ALU zero, signed-less-than, unsigned-borrow flags.
- RF_sel_in  in  3, RF_sel_out  out  3  write-back select, passed through.
- PC_sel  out  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR target.
- flush  out  1  squash younger instructions.
- redirect_pc  out  XLEN  correct next PC when flush=1, else 0.
- br_cnt, mis_cnt  out  32 each  resolved control-transfer count and mispredict count.

## Operation
- Index: pc[IDX_BITS+1:2]. Tag: pc[XLEN-1:IDX_BITS+2].
- Each entry holds valid, tag, target and a counter.
- Lookup is combinational from f_pc. pred_taken=1 iff valid, the tag matches, and the counter MSB is 1.
- Actual outcome:
  - BEQ: taken if Z. BNE: taken if !Z.
  - BLT: taken if N. BGE: taken if !N.
  - BLTU: taken if C. BGEU: taken if !C.
  - JAL and JALR: always taken.
  - funct3 010/011 under opcode 1100011, and JALR with funct3≠000, are not control transfers: no update, no flush.
- Correct next PC:
  - taken B: ex_br_target.
  - JAL: ex_br_target.
  - JALR: ex_jalr_target.
  - not taken: ex_pc+4, computed mod 2^XLEN.
- Mispredict: (actual≠ex_pred_taken) or (actual taken and ex_pred_target≠correct PC).
- On mispredict: flush=1, redirect_pc=correct PC.
- PC_sel reports the source of the correct PC: 00, 01, 10 or 11.
- Update, only when ex_valid and the instruction is B or JAL:
  - tag hit: counter saturating +1 if taken, −1 if not taken; target rewritten if taken.
  - tag miss, taken: allocate with tag, target, valid=1, counter=2^(CNT_BITS-1) (weakly taken). JAL allocates with the counter saturated at max.
  - tag miss, not taken: no write.
- JALR is never allocated or predicted. It flushes unless ex_pred_taken=1 and ex_pred_target matches.
- br_cnt increments on every valid resolved transfer. mis_cnt increments on every flush. Both wrap at 2^32.
- All other opcodes: RF_sel_out=RF_sel_in, PC_sel=00, flush=0.

## Timing
- Prediction and resolution outputs are combinational, with zero-cycle latency.
- Table writes and counter increments take effect at the next rising edge.
- Same-cycle f_pc and ex_pc at the same index: the lookup returns the pre-update entry (read before write).
- While rst=1: RF_sel_out=000, PC_sel=00, flush=0, redirect_pc=0, pred_taken=0, pred_target=0.
- At a rising edge with rst=1: all valid bits and counters clear (counters to 2^(CNT_BITS-1)−1, weakly not-taken), br_cnt and mis_cnt clear to 0.
- A reset asserted mid-operation discards the update pending in that cycle.
- ex_valid=0: no flush, no update, no count.

## Configuration
- BRANCH_PRED_EN defined: table, prediction and ex_pred_* comparison are present as described.
- BRANCH_PRED_EN undefined: no table storage is built, and pred_taken and pred_target are tied to 0.
  - Every taken transfer flushes; not-taken branches never flush.
  - Performance counters remain present.

## Test plan
- Reset, then f_pc=0x100 -> pred_taken=0, br_cnt=0, mis_cnt=0.
- BEQ at 0x100, Z=1, ex_pred_taken=0, target 0x140 -> flush=1, PC_sel=01, redirect_pc=0x140. Next cycle, f_pc=0x100 gives pred_taken=1, pred_target=0x140.
- Same BEQ resolved not-taken twice, with matching predictions -> first: flush=1, redirect 0x104. Second: flush=0. Afterwards pred_taken=0 for 0x100.
- BLTU with N=1, C=0 -> not taken, no flush. BGEU with C=0 -> taken.
- JALR at 0x200 to 0x300, not predicted -> flush=1, PC_sel=11, redirect_pc=0x300, table unchanged. funct3=010 branch -> flush=0, br_cnt unchanged.
- Set ex_valid=0 during a taken BNE, then assert rst mid-stream -> no flush, no count. After reset all predictions are 0.
